// File: rtl/sseg_adder_scan_pkg.sv
// rtl/sseg_adder_scan_pkg.sv - shared segment patterns, mode encodings and scan index type
package sseg_adder_scan_pkg;

  // Active-low cathodes, bit order G,F,E,D,C,B,A,p
  localparam logic [7:0] V0 = 8'h81;
  localparam logic [7:0] V1 = 8'hF3;
  localparam logic [7:0] V2 = 8'h49;
  localparam logic [7:0] V3 = 8'h61;
  localparam logic [7:0] V4 = 8'h33;
  localparam logic [7:0] V5 = 8'h25;
  localparam logic [7:0] V6 = 8'h05;
  localparam logic [7:0] V7 = 8'hF1;
  localparam logic [7:0] V8 = 8'h01;
  localparam logic [7:0] V9 = 8'h31;
  localparam logic [7:0] VA = 8'h11;
  localparam logic [7:0] VB = 8'h07;
  localparam logic [7:0] VC = 8'h8D;
  localparam logic [7:0] VD = 8'h43;
  localparam logic [7:0] VE = 8'h0D;
  localparam logic [7:0] VF = 8'h1D;
  localparam logic [7:0] VU = 8'h13;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] MODE_A     = 2'd0;
  localparam logic [1:0] MODE_B     = 2'd1;
  localparam logic [1:0] MODE_SUM   = 2'd2;
  localparam logic [1:0] MODE_UNDEF = 2'd3;

  typedef logic [2:0] scan_idx_t;

endpackage

// File: rtl/sseg_hex_decode.sv
// rtl/sseg_hex_decode.sv - combinational nibble to seven-segment pattern decoder
module sseg_hex_decode
  import sseg_adder_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'h0: pattern = V0;
      4'h1: pattern = V1;
      4'h2: pattern = V2;
      4'h3: pattern = V3;
      4'h4: pattern = V4;
      4'h5: pattern = V5;
      4'h6: pattern = V6;
      4'h7: pattern = V7;
      4'h8: pattern = V8;
      4'h9: pattern = V9;
      4'hA: pattern = VA;
      4'hB: pattern = VB;
      4'hC: pattern = VC;
      4'hD: pattern = VD;
      4'hE: pattern = VE;
      4'hF: pattern = VF;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_adder_scan.sv
// rtl/sseg_adder_scan.sv - registered adder with multiplexed seven-segment scan; SSEG_ADDER_SCAN_BLANK_EN blanks leading zeros
module sseg_adder_scan
  import sseg_adder_scan_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  input  logic [1:0]        mode,
  output logic [7:0]        sseg,
  output logic [DIGITS-1:0] AN
);

  localparam int NW = 4 * DIGITS;
  localparam int PW = $clog2(SCAN_DIV);

  if (NW < WIDTH + 1) begin : g_width_check
    $fatal(1, "sseg_adder_scan: 4*DIGITS must hold WIDTH+1 result bits");
  end

  logic [PW-1:0]     presc;
  logic              tick;
  scan_idx_t         idx;
  logic [WIDTH:0]    sum_q;
  logic [NW-1:0]     src;
  logic [3:0]        nib;
  logic [7:0]        dec;
  logic              blank;
  logic [7:0]        seg_next;
  logic [DIGITS-1:0] an_next;

  assign tick = (presc == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == scan_idx_t'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);
    end
  end

  always_comb begin
    src = '0;
    case (mode)
      MODE_A:  src = NW'(a);
      MODE_B:  src = NW'(b);
      default: src = NW'(sum_q);
    endcase
  end

  assign nib = 4'(src >> {idx, 2'b00});

`ifdef SSEG_ADDER_SCAN_BLANK_EN
  // Nothing left above the current nibble means this digit is a leading zero
  assign blank = (idx != '0) && ((src >> {idx, 2'b00}) == '0);
`else
  assign blank = 1'b0;
`endif

  sseg_hex_decode u_dec (
    .nibble  (nib),
    .pattern (dec)
  );

  always_comb begin
    seg_next = dec;
    if (mode == MODE_UNDEF) begin
      seg_next = VU;
    end else if (blank) begin
      seg_next = SEG_BLANK;
    end else if (mode == MODE_SUM && idx == '0 && sum_q[WIDTH]) begin
      seg_next[0] = 1'b0;
    end
  end

  assign an_next = ~(DIGITS'(1) << idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AN   <= '1;
      sseg <= SEG_BLANK;
    end else begin
      AN   <= an_next;
      sseg <= seg_next;
    end
  end

endmodule

// File: tb/tb_sseg_adder_scan.sv
// tb/tb_sseg_adder_scan.sv - scoreboard bench for sseg_adder_scan (WIDTH=8, DIGITS=4, SCAN_DIV=4)
module tb_sseg_adder_scan;

  localparam int WIDTH    = 8;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

`ifdef SSEG_ADDER_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [7:0] LEAD = BLANK ? 8'hFF : 8'h81;

  localparam logic [7:0] PAT [16] = '{8'h81, 8'hF3, 8'h49, 8'h61, 8'h33, 8'h25, 8'h05, 8'hF1,
                                     8'h01, 8'h31, 8'h11, 8'h07, 8'h8D, 8'h43, 8'h0D, 8'h1D};

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [7:0]       sseg;
  logic [DIGITS-1:0] AN;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_q [$];
  int          n_edges = 0;
  int          prev_sum = 0;
  int          m_idx = 0;
  logic [11:0] mon_e;

  always #5 clk = ~clk;

  sseg_adder_scan #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .mode  (mode),
    .sseg  (sseg),
    .AN    (AN)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected {AN, sseg} for one digit slot, from the display rules directly
  function automatic logic [11:0] exp_out(int idx, logic [1:0] m, int av, int bv, int sv);
    int v;
    int msd;
    logic [7:0] seg;
    logic [3:0] an;
    an = 4'hF;
    an[idx] = 1'b0;
    v = (m == 2'd0) ? av : (m == 2'd1) ? bv : sv;
    if (m == 2'd3) begin
      seg = 8'h13;
    end else begin
      seg = PAT[(v >> (4 * idx)) & 15];
      msd = 0;
      for (int i = 0; i < DIGITS; i++)
        if (((v >> (4 * i)) & 15) != 0) msd = i;
      if (BLANK && idx > msd) seg = 8'hFF;
      if (m == 2'd2 && idx == 0 && sv > 255) seg[0] = 1'b0;
    end
    return {an, seg};
  endfunction

  // Reference model: slot index follows from edges counted since reset release
  always @(posedge clk) begin
    if (reset) begin
      n_edges = 0;
      prev_sum = 0;
      exp_q.push_back(12'hFFF);
    end else begin
      n_edges++;
      m_idx = ((n_edges - 1) / SCAN_DIV) % DIGITS;
      exp_q.push_back(exp_out(m_idx, mode, int'(a), int'(b), prev_sum));
      prev_sum = int'(a) + int'(b) + int'(cin);
    end
  end

  always @(posedge clk) begin
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      mon_e = exp_q.pop_front();
      check("sb_an", 32'(AN), 32'(mon_e[11:8]));
      check("sb_sseg", 32'(sseg), 32'(mon_e[7:0]));
    end
  end

  task automatic check_digits(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e;
    bit ok;
    for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
      @(posedge clk);
      #2;
      ok = 1'b1;
      e = 8'h00;
      case (AN)
        4'b1110: e = e0;
        4'b1101: e = e1;
        4'b1011: e = e2;
        4'b0111: e = e3;
        default: begin
          ok = 1'b0;
          check({tag, "_an_onehot"}, 32'(AN), 32'hE);
        end
      endcase
      if (ok) check(tag, 32'(sseg), 32'(e));
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_an", 32'(AN), 32'hF);
    check("rst_sseg", 32'(sseg), 32'hFF);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    check("rel_an_first", 32'(AN), 32'hE);
    repeat (4) @(posedge clk);
    #2;
    check("rel_an_second", 32'(AN), 32'hD);

    @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 1'b0; mode = 2'd2;
    @(posedge clk);
    check_digits("ovf_digit", 8'h80, 8'h81, 8'hF3, LEAD);

    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); mode = 2'd3;
    check_digits("undef_digit", 8'h13, 8'h13, 8'h13, 8'h13);

    @(negedge clk);
    a = 8'hA5; mode = 2'd0;
    check_digits("a5_digit", 8'h25, 8'h11, LEAD, LEAD);

    @(negedge clk);
    a = 8'h05;
    check_digits("lead_digit", 8'h25, LEAD, LEAD, LEAD);

    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (AN == 4'b1011) break;
    end
    check("wait_an_1011", 32'(AN), 32'hB);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_an", 32'(AN), 32'hF);
    check("async_rst_sseg", 32'(sseg), 32'hFF);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    check("restart_an", 32'(AN), 32'hE);

    repeat (400) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 31));
    end

    repeat (3) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
